// File: rtl/operand_fetch.sv
// Operand fetch stage: latches an instruction, reads its two source registers,
// forwards register file writes into the operands and presents a decoded bundle to execute.
module operand_fetch #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_instr,
    input  logic [WIDTH-1:0]            in_pc,
    output logic [$clog2(SIZE)-1:0]     rf_ra,
    output logic [$clog2(SIZE)-1:0]     rf_rb,
    input  logic [WIDTH-1:0]            rf_a,
    input  logic [WIDTH-1:0]            rf_b,
    input  logic                        wb_wn,
    input  logic [$clog2(SIZE)-1:0]     wb_rw,
    input  logic [WIDTH-1:0]            wb_wd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_pc,
    output logic [WIDTH-1:0]            out_a,
    output logic [WIDTH-1:0]            out_b,
    output logic [WIDTH-1:0]            out_imm,
    output logic [5:0]                  out_opcode,
    output logic [5:0]                  out_funct,
    output logic [4:0]                  out_rs,
    output logic [4:0]                  out_rt,
    output logic [4:0]                  out_rd,
    output logic [4:0]                  out_shamt,
    output logic [4:0]                  out_dest
);
    localparam int unsigned SZW = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc_q;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             accept;

    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign in_ready = !flush && (state == IDLE || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    // Present the incoming indices while accepting so data arrives in READ.
    assign rf_ra = in_ready ? SZW'(in_instr[25:21]) : SZW'(rs);
    assign rf_rb = in_ready ? SZW'(in_instr[20:16]) : SZW'(rt);

    // Register zero reads as zero; otherwise a matching write-back wins over cur.
    function automatic logic [WIDTH-1:0] pick(input logic [4:0] r, input logic [WIDTH-1:0] cur,
                                              input logic wn, input logic [SZW-1:0] rw,
                                              input logic [WIDTH-1:0] wd);
        if (r == 5'd0)
            return '0;
        if (wn && rw == SZW'(r))
            return wd;
        return cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= in_instr;
                        pc_q    <= in_pc;
                        state   <= READ;
                    end
                end
                READ: begin
                    out_a     <= pick(rs, rf_a, wb_wn, wb_rw, wb_wd);
                    out_b     <= pick(rt, rf_b, wb_wn, wb_rw, wb_wd);
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            instr_q <= in_instr;
                            pc_q    <= in_pc;
                            state   <= READ;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        out_a <= pick(rs, out_a, wb_wn, wb_rw, wb_wd);
                        out_b <= pick(rt, out_b, wb_wn, wb_rw, wb_wd);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_pc     = pc_q;
    assign out_opcode = instr_q[31:26];
    assign out_rs     = rs;
    assign out_rt     = rt;
    assign out_rd     = instr_q[15:11];
    assign out_shamt  = instr_q[10:6];
    assign out_funct  = instr_q[5:0];

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        out_imm = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};
        if (out_opcode == 6'h0C || out_opcode == 6'h0D || out_opcode == 6'h0E)
            out_imm = {{(WIDTH-16){1'b0}}, instr_q[15:0]};
    end

    always_comb begin
        out_dest = rt;
        case (out_opcode)
            6'h00:                                    out_dest = out_rd;
            6'h03:                                    out_dest = 5'd31;
            6'h02, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: out_dest = 5'd0;
            default:                                  out_dest = rt;
        endcase
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/instruction width.
REQ-002 SHALL have parameter SIZE, default 32, register count; index width SZW = clog2(SIZE).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous discard of all in-flight state.
REQ-006 in_valid / in_ready  input / output  1 / 1  instruction handshake from fetch.
REQ-007 in_instr, in_pc  input  WIDTH each  instruction word and its PC.
REQ-008 rf_ra, rf_rb  output  SZW each  read indices to register file (combinational mux, see REQ-015).
REQ-009 rf_a, rf_b  input  WIDTH each  register file read data, valid the cycle after the index is presented at a posedge.
REQ-010 wb_wn, wb_rw, wb_wd  input  1/SZW/WIDTH  snoop of register file write port.
REQ-011 out_valid / out_ready  output / input  1 / 1  decoded-bundle handshake to execute.
REQ-012 out_pc, out_a, out_b, out_imm  output  WIDTH each  PC, operand A (rs), operand B (rt), extended immediate.
REQ-013 out_opcode, out_funct  output  6 each; out_rs, out_rt, out_rd, out_shamt, out_dest  output  5 each.

Function
REQ-014 SHALL implement FSM IDLE, READ, HOLD; in_ready = !flush && (state==IDLE || (state==HOLD && out_ready)).
REQ-015 rf_ra/rf_rb SHALL equal in_instr[25:21]/[20:16] when in_ready is high, else the latched rs/rt.
REQ-016 Accept (in_valid && in_ready) at edge N SHALL latch instr, pc, rs, rt and go to READ; out_valid SHALL rise after edge N+1 (latency 2 edges).
REQ-017 READ -> HOLD unconditionally at next edge, loading out_a/out_b from rf_a/rf_b.
REQ-018 Bypass: at any edge loading or holding out_a, if wb_wn && wb_rw==rs && rs!=0, out_a SHALL take wb_wd; same rule for out_b with rt.
REQ-019 HOLD: out_valid=1; if out_ready and no new accept -> IDLE; if out_ready and accept -> READ (back-to-back, one instruction per 2 cycles); else stay, outputs stable except REQ-018 bypass.
REQ-020 rs/rt == 0 SHALL yield operand 0 regardless of rf data or bypass.
REQ-021 out_imm = zero-extend(instr[15:0]) for opcodes 0x0C,0x0D,0x0E; sign-extend otherwise.
REQ-022 out_dest = rd for opcode 0x00; 31 for 0x03; 0 for 0x02,0x04,0x05,0x28,0x29,0x2B; rt otherwise.
REQ-023 flush SHALL take priority over all transitions: next state IDLE, out_valid 0, no accept that cycle.
REQ-024 in_valid low in IDLE SHALL keep state IDLE; no output changes.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, out_valid 0, all latched fields and data outputs 0, independent of clk.
REQ-026 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-027 Reset mid-READ or mid-HOLD SHALL discard the instruction; no bundle emitted for it.

Verification
REQ-028 Reg 8=0x11, reg 9=0x22; accept add $10,$8,$9 (0x01095020) at edge N -> out_valid after N+1, out_a=0x11, out_b=0x22, out_dest=10.
REQ-029 Same instruction, wb_wn=1, wb_rw=8, wb_wd=0xABCD during READ -> out_a=0xABCD; during HOLD with out_ready=0 -> out_a updates to new wb_wd next edge.
REQ-030 ori $9,$0,0x8000 -> out_imm=0x00008000, out_a=0, out_dest=9; addi same imm -> out_imm=0xFFFF8000.
REQ-031 out_ready held 0 for 5 cycles in HOLD -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> next instruction accepted same edge, out_valid drops one cycle.
REQ-032 flush asserted in READ, and separately with in_valid=1 in IDLE -> IDLE, out_valid=0, no bundle emitted, in_ready=0 during flush.
REQ-033 rst_n pulsed low mid-HOLD between edges -> out_valid=0 immediately, all outputs 0, in_ready=1 after release.
